// File: rtl/ofdm_pkg.sv
// Shared OFDM transmit-chain constants and types used by the bit interleaver.
package ofdm_pkg;

    localparam int unsigned ILV_ROWS = 8;
    localparam int unsigned ILV_COLS = 6;
    localparam int unsigned ILV_N    = ILV_ROWS * ILV_COLS;
    localparam int unsigned ILV_AW   = $clog2(ILV_N);
    localparam int unsigned ILV_RW   = $clog2(ILV_ROWS);
    localparam int unsigned ILV_CW   = $clog2(ILV_COLS);

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

endpackage

// File: rtl/ilv_rd_addr.sv
// Column-wise read address generator: row steps every bit, column steps on row wrap.
module ilv_rd_addr
    import ofdm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ILV_AW-1:0] addr,
    output logic              last
);

    logic [ILV_RW-1:0] row;
    logic [ILV_CW-1:0] col;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (row == ILV_RW'(ILV_ROWS - 1)) begin
                row <= '0;
                col <= (col == ILV_CW'(ILV_COLS - 1)) ? '0 : col + 1'b1;
            end else begin
                row <= row + 1'b1;
            end
        end
    end

    // Linear address of the row-wise written block: row*COLS + col.
    assign addr = ILV_AW'(ILV_AW'(row) * ILV_AW'(ILV_COLS) + ILV_AW'(col));
    assign last = (row == ILV_RW'(ILV_ROWS - 1)) && (col == ILV_CW'(ILV_COLS - 1));

endmodule

// File: rtl/bit_interleaver.sv
// Ping-pong block interleaver: write row-wise, read column-wise, ROWS x COLS bits per block.
// Optional ILV_BYPASS_EN adds a bypass input that passes bits straight through when fully idle.
module bit_interleaver
    import ofdm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic in_valid,
`ifdef ILV_BYPASS_EN
    input  logic bypass,
`endif
    output logic out,
    output logic out_valid,
    output logic out_sop,
    output logic ovf
);

    logic [ILV_N-1:0]  mem [2];
    logic [ILV_AW-1:0] wcnt;
    logic              wbank;
    logic              rbank;
    logic [1:0]        full;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;

    rd_state_t         state;
    rd_state_t         state_n;
    logic              done;
    logic              done_n;
    logic              out_d;
    logic              valid_d;
    logic              sop_d;
    logic              adv;
    logic              clr;
    logic              rel;
    logic              nbank;

    logic [ILV_AW-1:0] rd_addr;
    logic              rd_last;

    logic              byp_ok;
    logic              wr_req;
    logic              wr_ok;

`ifdef ILV_BYPASS_EN
    assign byp_ok = bypass && (state == RD_IDLE) && (full == 2'b00) && (wcnt == '0);
`else
    assign byp_ok = 1'b0;
`endif

    assign wr_req = in_valid && !byp_ok;
    assign wr_ok  = wr_req && !full[wbank];
    assign nbank  = ~rbank;

    ilv_rd_addr u_rd_addr (
        .clk     (clk),
        .reset   (reset),
        .clear   (clr),
        .advance (adv),
        .addr    (rd_addr),
        .last    (rd_last)
    );

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wbank][wcnt] <= in;
        end
    end

    always_comb begin
        full_set = 2'b00;
        full_clr = 2'b00;
        if (wr_ok && (wcnt == ILV_AW'(ILV_N - 1))) begin
            full_set[wbank] = 1'b1;
        end
        if (rel) begin
            full_clr[rbank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt  <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            full  <= 2'b00;
            ovf   <= 1'b0;
        end else begin
            if (wr_req && full[wbank]) begin
                ovf <= 1'b1;
            end
            if (wr_ok) begin
                if (wcnt == ILV_AW'(ILV_N - 1)) begin
                    wcnt  <= '0;
                    wbank <= ~wbank;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            full <= (full & ~full_clr) | full_set;
            if (rel) begin
                rbank <= ~rbank;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RD_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Reader: done marks that the last bit of the bank left on the previous edge.
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        out_d   = 1'b0;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        adv     = 1'b0;
        clr     = 1'b0;
        rel     = 1'b0;
        case (state)
            RD_IDLE: begin
                if (full[rbank]) begin
                    out_d   = mem[rbank][rd_addr];
                    valid_d = 1'b1;
                    sop_d   = 1'b1;
                    adv     = 1'b1;
                    state_n = RD_READ;
                end else begin
                    clr = 1'b1;
                end
            end
            RD_READ: begin
                if (done) begin
                    rel = 1'b1;
                    if (full[nbank]) begin
                        out_d   = mem[nbank][rd_addr];
                        valid_d = 1'b1;
                        sop_d   = 1'b1;
                        adv     = 1'b1;
                    end else begin
                        clr     = 1'b1;
                        state_n = RD_IDLE;
                    end
                end else begin
                    out_d   = mem[rbank][rd_addr];
                    valid_d = 1'b1;
                    adv     = 1'b1;
                    done_n  = rd_last;
                end
            end
            default: begin
                state_n = RD_IDLE;
                clr     = 1'b1;
            end
        endcase
        if (byp_ok) begin
            out_d   = in;
            valid_d = in_valid;
            sop_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            done      <= 1'b0;
        end else begin
            out       <= out_d;
            out_valid <= valid_d;
            out_sop   <= sop_d;
            done      <= done_n;
        end
    end

endmodule
